// File: rtl/uart_rx_word.sv
// UART receiver that packs WORD_BYTES bytes (first byte in the top byte) into one word behind a valid/ready handshake.
// Optional parity checking is enabled with `define UART_RX_PARITY_EN (adds parameter PARITY_ODD).
module uart_rx_word #(
    parameter int CLKS_PER_BIT      = 1085,
    parameter int WORD_BYTES        = 2,
    parameter int SYNC_STAGES       = 2,
    parameter int IDLE_TIMEOUT_BITS = 20
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD        = 1'b0
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    rx,
    output logic [8*WORD_BYTES-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    frame_err_o,
    output logic                    overrun_o,
    output logic                    timeout_o,
    output logic                    parity_err_o
);
    localparam int W       = 8 * WORD_BYTES;
    localparam int AW      = (WORD_BYTES > 1) ? 8 * (WORD_BYTES - 1) : 8;
    localparam int BW      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int TO_CYC  = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_LAST = (TO_CYC > 0) ? TO_CYC - 1 : 0;
    localparam int IW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam bit TO_EN   = (IDLE_TIMEOUT_BITS > 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             sh;
    logic [AW-1:0]          acc;
    logic [W-1:0]           acc_n;
    logic [BW-1:0]          byte_cnt;
    logic [IW-1:0]          idle_cnt;
    logic                   armed;
    logic                   par_bad;
    logic                   cnt_clr, cnt_inc, sample_data, sample_par, stop_sample;
    logic                   to_hit;

    assign rx_s   = sync[SYNC_STAGES-1];
    assign busy_o = (state != IDLE) || (byte_cnt != '0);
    assign to_hit = TO_EN && enable && (state == IDLE) && (state_n == IDLE) &&
                    (byte_cnt != '0) && (idle_cnt == IW'(TO_LAST));

    generate
        if (WORD_BYTES == 1) begin : g_one
            assign acc_n = sh;
        end else begin : g_multi
            assign acc_n = {acc, sh};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '1;
            state <= IDLE;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rx};
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_n = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (cnt == CW'(CLKS_PER_BIT / 2)) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? IDLE : DATA;
                end else cnt_inc = 1'b1;
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_clr     = 1'b1;
                    sample_data = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PARITY;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end else cnt_inc = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_clr    = 1'b1;
                    sample_par = 1'b1;
                    state_n    = STOP;
                end else cnt_inc = 1'b1;
            end
`endif
            STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_clr     = 1'b1;
                    stop_sample = 1'b1;
                    state_n     = IDLE;
                end else cnt_inc = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (!enable) begin
            state_n     = IDLE;
            cnt_clr     = 1'b1;
            cnt_inc     = 1'b0;
            sample_data = 1'b0;
            sample_par  = 1'b0;
            stop_sample = 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_bad <= 1'b0;
        else if (sample_par) par_bad <= ((^sh) ^ rx_s) != PARITY_ODD;
    end
`else
    assign par_bad = 1'b0;
    logic unused_par;
    assign unused_par = sample_par;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            bit_idx      <= '0;
            sh           <= '0;
            acc          <= '0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            armed        <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
            parity_err_o <= 1'b0;

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (state != DATA)    bit_idx <= '0;
            else if (sample_data) bit_idx <= bit_idx + 1'b1;
            if (sample_data) sh <= {rx_s, sh[7:1]};

            // a bad stop bit leaves the line low; wait for it to return high before re-arming
            if (!enable)                  armed <= 1'b0;
            else if (stop_sample && !rx_s) armed <= 1'b0;
            else if (state == IDLE && rx_s) armed <= 1'b1;

            if (valid_o && ready_i) valid_o <= 1'b0;

            if (stop_sample) begin
                if (!rx_s) begin
                    frame_err_o <= 1'b1;
                    byte_cnt    <= '0;
                end else if (par_bad) begin
                    parity_err_o <= 1'b1;
                    byte_cnt     <= '0;
                end else begin
                    acc <= acc_n[AW-1:0];
                    if (byte_cnt == BW'(WORD_BYTES - 1)) begin
                        byte_cnt <= '0;
                        if (!valid_o || ready_i) begin
                            data_o  <= acc_n;
                            valid_o <= 1'b1;
                        end else overrun_o <= 1'b1;
                    end else byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (to_hit) begin
                byte_cnt  <= '0;
                timeout_o <= 1'b1;
            end
            if (!enable) byte_cnt <= '0;

            if (!enable || state_n != IDLE || byte_cnt == '0 || to_hit) idle_cnt <= '0;
            else if (state == IDLE) idle_cnt <= idle_cnt + 1'b1;
        end
    end
endmodule
